// File: rtl/serializer_pkg.sv
// Shared types for the word serializer: FSM state encoding and gap counter width.
package serializer_pkg;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SHIFT,
        SER_GAP
    } ser_state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / bit-out bundle of the serializer; master is the word source, slave is the serializer.
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, dout, dout_valid, frame_start, frame_end, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, dout, dout_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/ser_shift_reg.sv
// Loadable shift register with registered serial output; one bit per load/shift, 0 otherwise.
// With SERIALIZER_PARITY_EN it accumulates the XOR of emitted data bits and can emit it as a trailing bit.
module ser_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
`ifdef SERIALIZER_PARITY_EN
    input  logic             emit_par,
`endif
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out
);

    logic [WIDTH-1:0] sreg;
`ifdef SERIALIZER_PARITY_EN
    logic             par;
`endif

    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // The first bit leaves on the load edge itself, so sreg always holds only the unsent bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg    <= '0;
            ser_out <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (load) begin
            ser_out <= head(load_data);
            sreg    <= advance(load_data);
`ifdef SERIALIZER_PARITY_EN
            par     <= head(load_data);
`endif
        end else if (shift) begin
            ser_out <= head(sreg);
            sreg    <= advance(sreg);
`ifdef SERIALIZER_PARITY_EN
            par     <= par ^ head(sreg);
        end else if (emit_par) begin
            ser_out <= par;
`endif
        end else begin
            ser_out <= 1'b0;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Serializes WIDTH-bit words onto dout, bit k of a word accepted in cycle A appears in A+1+k; in_ready is
// registered and drops while a frame/gap is in progress. Optional trailing even-parity bit: SERIALIZER_PARITY_EN.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    word_serializer_if.slave   bus
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int BCW = $clog2(WIDTH + 2);
    localparam logic [BCW-1:0]       LAST_IDX = BCW'(FRAME_LEN - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_t           state;
    logic [BCW-1:0]       bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 in_ready_q;
    logic                 dout_valid_q;
    logic                 frame_start_q;
    logic                 frame_end_q;

    logic                 accept;
    logic                 last_bit;
    logic                 step;
    logic                 shift_en;
    logic [BCW-1:0]       next_cnt;

    assign accept   = bus.in_valid && in_ready_q;
    assign last_bit = (state == SER_SHIFT) && (bit_cnt == LAST_IDX);
    assign step     = (state == SER_SHIFT) && !last_bit;
    assign next_cnt = bit_cnt + BCW'(1);

`ifdef SERIALIZER_PARITY_EN
    logic emit_par;
    assign emit_par = step && (bit_cnt == BCW'(WIDTH - 1));
    assign shift_en = step && !emit_par;
`else
    assign shift_en = step;
`endif

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .shift     (shift_en),
`ifdef SERIALIZER_PARITY_EN
        .emit_par  (emit_par),
`endif
        .load_data (bus.in_data),
        .ser_out   (bus.dout)
    );

    // bit_cnt holds the index of the bit currently on dout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SER_IDLE;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            in_ready_q    <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            unique case (state)
                SER_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state         <= SER_SHIFT;
                        bit_cnt       <= '0;
                        in_ready_q    <= 1'b0;
                        dout_valid_q  <= 1'b1;
                        frame_start_q <= 1'b1;
                    end
                end
                SER_SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt     <= next_cnt;
                        frame_end_q <= (next_cnt == LAST_IDX);
                        in_ready_q  <= (GAP_CYCLES == 0) && (next_cnt == LAST_IDX);
                    end else if (accept) begin
                        bit_cnt       <= '0;
                        frame_start_q <= 1'b1;
                        in_ready_q    <= 1'b0;
                    end else if (GAP_CYCLES > 0) begin
                        state        <= SER_GAP;
                        gap_cnt      <= '0;
                        dout_valid_q <= 1'b0;
                        in_ready_q   <= 1'b0;
                    end else begin
                        state        <= SER_IDLE;
                        dout_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                    end
                end
                SER_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state      <= SER_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_CNT_W'(1);
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.busy        = (state != SER_IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Drives three serializer configurations (MSB/gap0, LSB/gap0, MSB/gap3) against a per-cycle frame model.
module tb_word_serializer;

    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int ND = 3;
    localparam int MSB[ND]  = '{1, 0, 1};
    localparam int GAPS[ND] = '{0, 0, 3};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         tb_valid [ND];
    logic [W-1:0] tb_data  [ND];
    logic [ND-1:0] o_ready, o_dout, o_dv, o_fs, o_fe, o_busy;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        word_serializer_if #(.WIDTH(W)) bus ();
        assign bus.in_valid = tb_valid[g];
        assign bus.in_data  = tb_data[g];
        assign o_ready[g]   = bus.in_ready;
        assign o_dout[g]    = bus.dout;
        assign o_dv[g]      = bus.dout_valid;
        assign o_fs[g]      = bus.frame_start;
        assign o_fe[g]      = bus.frame_end;
        assign o_busy[g]    = bus.busy;
        word_serializer #(.WIDTH(W), .MSB_FIRST(MSB[g]), .GAP_CYCLES(GAPS[g])) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: pending frame as a bit list plus cycles since the last frame end.
    int       rem[ND], kidx[ND], since_end[ND];
    bit       first[ND], acc[ND];
    logic [8:0] stream[ND];
    // Observed-side capture.
    logic [8:0] cap[ND], last_frame[ND];
    int       cap_pos[ND], run[ND], run_at_end[ND], idle[ND], gap_at_start[ND], frame_cnt[ND];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    endtask

    task automatic model_cycle(input int d);
        bit has, exp_bit, is_start, is_end, in_gap, exp_rdy;
        has = 0; exp_bit = 0; is_start = 0; is_end = 0;
        if (reset) begin
            check("rst_dout_valid", d, 32'(o_dv[d]), 0);
            check("rst_dout", d, 32'(o_dout[d]), 0);
            check("rst_frame_end", d, 32'(o_fe[d]), 0);
            check("rst_in_ready", d, 32'(o_ready[d]), 0);
            check("rst_busy", d, 32'(o_busy[d]), 0);
            rem[d] = 0; first[d] = 1; since_end[d] = 100; run[d] = 0; acc[d] = 0; cap_pos[d] = 0;
            return;
        end
        has = rem[d] > 0;
        if (has) begin
            exp_bit  = stream[d][kidx[d]];
            is_start = (kidx[d] == 0);
            is_end   = (kidx[d] == FL - 1);
            kidx[d]++;
            rem[d]--;
        end else if (since_end[d] < 100) begin
            since_end[d]++;
        end
        in_gap  = !has && since_end[d] >= 1 && since_end[d] <= GAPS[d];
        exp_rdy = !first[d] && (has ? (is_end && GAPS[d] == 0) : !in_gap);
        check("dout_valid", d, 32'(o_dv[d]), 32'(has));
        check("dout", d, 32'(o_dout[d]), 32'(has && exp_bit));
        check("frame_start", d, 32'(o_fs[d]), 32'(has && is_start));
        check("frame_end", d, 32'(o_fe[d]), 32'(has && is_end));
        check("in_ready", d, 32'(o_ready[d]), 32'(exp_rdy));
        check("busy", d, 32'(o_busy[d]), 32'(has || in_gap));
        if (has && is_end) since_end[d] = 0;
        first[d] = 0;

        if (o_dv[d]) begin
            if (o_fs[d]) begin
                cap_pos[d] = 0;
                gap_at_start[d] = idle[d];
            end
            if (cap_pos[d] < 9) cap[d][cap_pos[d]] = o_dout[d];
            cap_pos[d]++;
            run[d]++;
            idle[d] = 0;
            if (o_fe[d]) begin
                last_frame[d] = cap[d];
                frame_cnt[d]++;
                run_at_end[d] = run[d];
            end
        end else begin
            run[d] = 0;
            idle[d]++;
        end

        acc[d] = tb_valid[d] && o_ready[d];
        if (acc[d]) begin
            check("no_overlap", d, 32'(rem[d]), 0);
            stream[d] = '0;
            for (int k = 0; k < W; k++)
                stream[d][k] = (MSB[d] != 0) ? tb_data[d][W-1-k] : tb_data[d][k];
`ifdef SERIALIZER_PARITY_EN
            stream[d][W] = ^tb_data[d];
`endif
            rem[d] = FL;
            kidx[d] = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < ND; d++) model_cycle(d);
        @(posedge clk);
        #1;
    endtask

    // Present a word and return once it is accepted; optionally leave in_valid high.
    task automatic send(input int d, input logic [W-1:0] w, input bit hold);
        bit got;
        got = 0;
        tb_valid[d] = 1'b1;
        tb_data[d]  = w;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            got = acc[d];
        end
        if (!got) check("accept_timeout", d, 0, 1);
        if (!hold) begin
            tb_valid[d] = 1'b0;
            tb_data[d]  = W'($urandom);
        end
    endtask

    task automatic wait_frames(input int d, input int target);
        for (int i = 0; i < 80 && frame_cnt[d] < target; i++) tick();
        if (frame_cnt[d] < target) check("frame_timeout", d, 32'(frame_cnt[d]), 32'(target));
    endtask

    function automatic logic [8:0] expected_frame(input logic [7:0] lit, input logic par);
        logic [8:0] f;
        f = '0;
        for (int k = 0; k < W; k++) f[k] = lit[W-1-k];
`ifdef SERIALIZER_PARITY_EN
        f[W] = par;
`else
        if (par) f[W] = 1'b0;
`endif
        return f;
    endfunction

    typedef struct {
        logic [7:0] word;
        logic [7:0] msb_stream;  // bit 7 = first bit sent
        logic [7:0] lsb_stream;
        logic       par;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int c;
        tbl[0] = '{8'hF0, 8'b11110000, 8'b00001111, 1'b0};
        tbl[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
        tbl[2] = '{8'hAA, 8'b10101010, 8'b01010101, 1'b0};
        tbl[3] = '{8'h55, 8'b01010101, 8'b10101010, 1'b0};
        tbl[4] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
        tbl[5] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};
        for (int d = 0; d < ND; d++) begin
            tb_valid[d] = 1'b0; tb_data[d] = '0;
            rem[d] = 0; kidx[d] = 0; since_end[d] = 100; first[d] = 1; acc[d] = 0;
            stream[d] = '0; cap[d] = '0; last_frame[d] = '0; cap_pos[d] = 0;
            run[d] = 0; run_at_end[d] = 0; idle[d] = 0; gap_at_start[d] = 0; frame_cnt[d] = 0;
        end

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Table: each word on the MSB-first and LSB-first instances.
        foreach (tbl[i]) begin
            for (int d = 0; d < 2; d++) begin
                c = frame_cnt[d];
                send(d, tbl[i].word, 1'b0);
                wait_frames(d, c + 1);
                check("frame_bits", d, 32'(last_frame[d] & 9'((1 << FL) - 1)),
                      32'(expected_frame((MSB[d] != 0) ? tbl[i].msb_stream : tbl[i].lsb_stream, tbl[i].par)
                          & 9'((1 << FL) - 1)));
            end
        end

        // Back-to-back with in_valid held: no bubble when GAP_CYCLES=0.
        c = frame_cnt[0];
        send(0, 8'hAA, 1'b1);
        send(0, 8'h55, 1'b0);
        wait_frames(0, c + 2);
        check("b2b_run", 0, 32'(run_at_end[0]), 32'(2 * FL));

        // Same on the gap instance: frames separated by the gap plus one idle cycle.
        c = frame_cnt[2];
        send(2, 8'hAA, 1'b1);
        send(2, 8'h55, 1'b0);
        wait_frames(2, c + 2);
        check("gap_run", 2, 32'(run_at_end[2]), 32'(FL));
        check("gap_len", 2, 32'(gap_at_start[2]), 32'(GAPS[2] + 1));
        check("gap_frame_bits", 2, 32'(last_frame[2] & 9'((1 << FL) - 1)),
              32'(expected_frame(8'b01010101, 1'b0) & 9'((1 << FL) - 1)));

        // Reset in cycle A+4 of an 8'hFF frame.
        c = frame_cnt[0];
        send(0, 8'hFF, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_no_frame_end", 0, 32'(frame_cnt[0]), 32'(c));
        reset = 1'b0;
        repeat (2) tick();
        c = frame_cnt[0];
        send(0, 8'h80, 1'b0);
        wait_frames(0, c + 1);
        check("post_abort_bits", 0, 32'(last_frame[0] & 9'((1 << FL) - 1)),
              32'(expected_frame(8'b10000000, 1'b1) & 9'((1 << FL) - 1)));

        // Random traffic with in_valid dropping, data churning, and one mid-run reset.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < ND; d++) begin
                tb_valid[d] = ($urandom % 3) != 0;
                tb_data[d]  = W'($urandom);
            end
            reset = (cyc == 200);
            tick();
        end
        reset = 1'b0;
        for (int d = 0; d < ND; d++) tb_valid[d] = 1'b0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
